external_bus_ctrl: RTL

- Parametrised successor to the CPU's single-cycle external bus.
- Arbitrates MBR/MAR traffic onto ROM (instruction) or RAM (data) through a registered transaction FSM.
- Adds latched request operands, memory wait-state handshake (i_mem_ready), timeout, illegal-request error flag and a done pulse for the control unit.
- Sits between the CPU register file (MBR/MAR) and the instruction ROM / data RAM.

---
 rtl/ext_bus_pkg.sv | 26 ++
 rtl/bus_wait_timer.sv | 32 +++
 rtl/external_bus_ctrl.sv | 135 +++++++++++++
 3 files changed

// File: rtl/ext_bus_pkg.sv
// Shared definitions for the external bus controller: FSM states, operation
// encoding, default bus widths and the request legality rule.
package ext_bus_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    DONE   = 2'd2
  } ext_bus_state_e;

  typedef enum logic {
    OP_READ  = 1'b0,
    OP_WRITE = 1'b1
  } ext_bus_op_e;

  localparam int unsigned DEF_DATA_W = 16;
  localparam int unsigned DEF_ADDR_W = 8;

  // A request is illegal when both directions are asked for at once, or
  // when a write targets the read-only instruction memory.
  function automatic logic is_illegal_req(input logic rd, input logic wr,
                                          input logic rom);
    return (rd && wr) || (wr && rom);
  endfunction

endpackage

// File: rtl/bus_wait_timer.sv
// Wait-state counter for a bus access: counts stalled cycles, saturates at
// TIMEOUT and flags the cycle in which one more stall would hit TIMEOUT.
module bus_wait_timer #(
  parameter int unsigned TIMEOUT = 15
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_clear,
  input  logic i_inc,
  output logic o_last
);

  localparam int unsigned CW = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] CNT_MAX  = CW'(TIMEOUT);
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

  logic [CW-1:0] r_count;

  // Stall counter: cleared between transactions, never wraps.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_count <= '0;
    end else if (i_clear) begin
      r_count <= '0;
    end else if (i_inc && (r_count != CNT_MAX)) begin
      r_count <= r_count + CW'(1);
    end
  end

  assign o_last = (r_count == CNT_LAST);

endmodule

// File: rtl/external_bus_ctrl.sv
// External bus controller: moves MBR/MAR traffic onto the instruction ROM or
// the data RAM through an IDLE/ACCESS/DONE transaction FSM with wait states,
// timeout, illegal-request detection and a done pulse for the control unit.
module external_bus_ctrl
  import ext_bus_pkg::*;
#(
  parameter int unsigned DATA_W  = DEF_DATA_W,
  parameter int unsigned ADDR_W  = DEF_ADDR_W,
  parameter int unsigned TIMEOUT = 15
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_req_read,
  input  logic              i_req_write,
  input  logic              i_sel_rom,
  input  logic [ADDR_W-1:0] i_mar_addr,
  input  logic [DATA_W-1:0] i_mbr_wdata,
  output logic [DATA_W-1:0] o_mbr_rdata,
  output logic              o_busy,
  output logic              o_done,
  output logic              o_err,
  output logic [ADDR_W-1:0] o_mem_addr,
  output logic [DATA_W-1:0] o_mem_wdata,
  output logic              o_rom_read,
  output logic              o_ram_read,
  output logic              o_ram_write,
  input  logic [DATA_W-1:0] i_rom_data,
  input  logic [DATA_W-1:0] i_ram_data,
  input  logic              i_mem_ready
);

  ext_bus_state_e    r_state;
  ext_bus_op_e       r_op;
  logic              r_sel_rom;
  logic [ADDR_W-1:0] r_addr;
  logic [DATA_W-1:0] r_wdata;
  logic [DATA_W-1:0] r_rdata;
  logic              r_err;

  logic w_access;
  logic w_done;
  logic w_wait_last;
  logic w_rom_rd;
  logic w_ram_rd;
  logic w_ram_wr;

  assign w_access = (r_state == ACCESS);
  assign w_done   = (r_state == DONE);

  bus_wait_timer #(
    .TIMEOUT(TIMEOUT)
  ) u_wait_timer (
    .i_clk  (i_clk),
    .i_rst  (i_rst),
    .i_clear(w_done),
    .i_inc  (w_access && !i_mem_ready),
    .o_last (w_wait_last)
  );

  // Transaction FSM: operand latching, completion, timeout and error flag.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state   <= IDLE;
      r_op      <= OP_READ;
      r_sel_rom <= 1'b0;
      r_addr    <= '0;
      r_wdata   <= '0;
      r_rdata   <= '0;
      r_err     <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (i_req_read || i_req_write) begin
            if (is_illegal_req(i_req_read, i_req_write, i_sel_rom)) begin
              r_err   <= 1'b1;
              r_state <= DONE;
            end else begin
              r_op      <= i_req_write ? OP_WRITE : OP_READ;
              r_sel_rom <= i_sel_rom;
              r_addr    <= i_mar_addr;
              r_wdata   <= i_mbr_wdata;
              r_state   <= ACCESS;
            end
          end
        end
        ACCESS: begin
          // Ready wins over an expiring wait counter in the same cycle.
          if (i_mem_ready) begin
            if (r_op == OP_READ) begin
              r_rdata <= r_sel_rom ? i_rom_data : i_ram_data;
            end
            r_state <= DONE;
          end else if (w_wait_last) begin
            r_err   <= 1'b1;
            r_state <= DONE;
          end
        end
        DONE: begin
          r_err   <= 1'b0;
          r_state <= IDLE;
        end
        default: begin
          r_state <= IDLE;
        end
      endcase
    end
  end

  // Strobe decode from latched operands; gated by ACCESS so reset kills them.
  always_comb begin
    w_rom_rd = 1'b0;
    w_ram_rd = 1'b0;
    w_ram_wr = 1'b0;
    if (w_access) begin
      if (r_op == OP_WRITE) begin
        w_ram_wr = !r_sel_rom;
      end else if (r_sel_rom) begin
        w_rom_rd = 1'b1;
      end else begin
        w_ram_rd = 1'b1;
      end
    end
  end

  assign o_rom_read  = w_rom_rd;
  assign o_ram_read  = w_ram_rd;
  assign o_ram_write = w_ram_wr;
  assign o_mem_addr  = w_access ? r_addr : '0;
  assign o_mem_wdata = w_ram_wr ? r_wdata : '0;
  assign o_mbr_rdata = r_rdata;
  assign o_busy      = w_access || w_done;
  assign o_done      = w_done;
  assign o_err       = w_done && r_err;

endmodule
